// File: rtl/iq_accumulator_pkg.sv
// Shared readout definitions: default widths, controller states and the I/Q packing order
// used by both this accumulator and the downstream normalizer.
package iq_accumulator_pkg;

  localparam int unsigned DefSampleWidth = 16;
  localparam int unsigned DefAccWidth    = 32;
  localparam int unsigned DefCntWidth    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  // I occupies the upper half of the packed word, Q the lower half.
  typedef struct packed {
    logic [DefAccWidth-1:0] i_sum;
    logic [DefAccWidth-1:0] q_sum;
  } iq_pair_t;

  function automatic logic [2*DefAccWidth-1:0] pack_iq(input logic [DefAccWidth-1:0] i_sum,
                                                       input logic [DefAccWidth-1:0] q_sum);
    iq_pair_t pair;
    pair.i_sum = i_sum;
    pair.q_sum = q_sum;
    return pair;
  endfunction

endpackage

// File: rtl/iq_channel_acc.sv
// Single-channel signed accumulator: sign-extends each enabled sample into a wider running sum.
// Clear has priority over enable.
module iq_channel_acc #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [IN_WIDTH-1:0]  sample,
  output logic [ACC_WIDTH-1:0] sum
);

  logic [ACC_WIDTH-1:0] sample_ext;
  logic [ACC_WIDTH-1:0] sum_q;

  assign sample_ext = {{(ACC_WIDTH - IN_WIDTH){sample[IN_WIDTH-1]}}, sample};
  assign sum        = sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= sum_q + sample_ext;
    end
  end

endmodule

// File: rtl/iq_accumulator.sv
// Integrates demodulated I/Q samples over a programmable window, then hands the sums to the
// inference wrapper with a one-cycle start pulse once the network reports idle.
module iq_accumulator
  import iq_accumulator_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = DefSampleWidth,
  parameter int unsigned ACC_WIDTH    = DefAccWidth,
  parameter int unsigned CNT_WIDTH    = DefCntWidth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    readout_trigger,
  input  logic [CNT_WIDTH-1:0]    window_len,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_q,
  input  logic                    nn_idle,
  output logic [2*ACC_WIDTH-1:0]  accumulated_data,
  output logic                    start_trigger,
  output logic                    busy,
  output logic                    trigger_dropped
);

  // A full-length window of extreme samples must never wrap the sums.
  if (ACC_WIDTH < SAMPLE_WIDTH + CNT_WIDTH) begin : g_width_check
    $fatal(1, "iq_accumulator: ACC_WIDTH must be >= SAMPLE_WIDTH + CNT_WIDTH");
  end

  state_e               state_q;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [ACC_WIDTH-1:0] i_sum;
  logic [ACC_WIDTH-1:0] q_sum;
  logic                 acc_clr;
  logic                 acc_en;

  assign acc_clr = (state_q == StIdle) && readout_trigger;
  assign acc_en  = (state_q == StAccum) && sample_valid;
  assign cnt_inc = cnt_q + CNT_WIDTH'(1);

  iq_channel_acc #(
    .IN_WIDTH (SAMPLE_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_acc_i (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .en    (acc_en),
    .sample(sample_i),
    .sum   (i_sum)
  );

  iq_channel_acc #(
    .IN_WIDTH (SAMPLE_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_acc_q (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .en    (acc_en),
    .sample(sample_q),
    .sum   (q_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      len_q            <= '0;
      cnt_q            <= '0;
      accumulated_data <= '0;
      start_trigger    <= 1'b0;
      busy             <= 1'b0;
      trigger_dropped  <= 1'b0;
    end else begin
      start_trigger   <= 1'b0;
      trigger_dropped <= readout_trigger && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (readout_trigger) begin
            // A zero-length request still integrates one sample.
            len_q   <= (window_len == '0) ? CNT_WIDTH'(1) : window_len;
            cnt_q   <= '0;
            state_q <= StAccum;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        StAccum: begin
          busy <= 1'b1;
          if (sample_valid) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == len_q) begin
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          if (nn_idle) begin
            accumulated_data <= {i_sum, q_sum};
            start_trigger    <= 1'b1;
            state_q          <= StIdle;
            busy             <= 1'b0;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
